// File: rtl/fir_tile_feeder.sv
// FIR tile feeder: one job = config beat, CFG_GAP idle cycles, num tap beats (descending index), one sample frame.
// Latency: 1 cycle from cfg/tap/sample handshake to tile beat; backpressure: sample ready follows tile_ready, taps never stall.
module fir_tile_feeder #(
    parameter int DW      = 16,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 16,
    parameter int CFG_GAP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_num,
    input  logic [1:0]        cfg_mode,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              tap_in_valid,
    output logic              tap_in_ready,
    input  logic [2*DW-1:0]   tap_in_data,
    input  logic              smp_in_valid,
    output logic              smp_in_ready,
    input  logic [2*DW-1:0]   smp_in_data,
    input  logic              tile_ready,
    output logic              cont_valid,
    output logic [CNT_W-1:0]  cont_num,
    output logic [1:0]        cont_mode,
    output logic              tap_valid,
    output logic [2*DW-1:0]   tap_data,
    output logic [CNT_W-1:0]  tap_count,
    output logic              smp_valid,
    output logic [2*DW-1:0]   smp_data,
    output logic              busy,
    output logic              cfg_err
);

    localparam int GAP_W = (CFG_GAP < 1) ? 1 : $clog2(CFG_GAP + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_GAP,
        ST_TAP,
        ST_STREAM
    } state_t;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cpx_t;

    state_t              state_q, state_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [CNT_W-1:0]    k_q, k_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                cfg_err_q, cfg_err_d;
    logic                cont_valid_q, cont_valid_d;
    logic [CNT_W-1:0]    cont_num_q, cont_num_d;
    logic [1:0]          cont_mode_q, cont_mode_d;
    logic                tap_valid_q, tap_valid_d;
    cpx_t                tap_data_q, tap_data_d;
    logic [CNT_W-1:0]    tap_count_q, tap_count_d;
    logic                smp_valid_q, smp_valid_d;
    cpx_t                smp_data_q, smp_data_d;
    logic                smp_rdy;

    assign smp_rdy      = (state_q == ST_STREAM) && tile_ready && (rem_q != '0);
    assign smp_in_ready = smp_rdy;
    assign cfg_ready    = (state_q == ST_IDLE);
    assign tap_in_ready = (state_q == ST_TAP);
    assign busy         = (state_q != ST_IDLE);

    assign cfg_err      = cfg_err_q;
    assign cont_valid   = cont_valid_q;
    assign cont_num     = cont_num_q;
    assign cont_mode    = cont_mode_q;
    assign tap_valid    = tap_valid_q;
    assign tap_data     = tap_data_q;
    assign tap_count    = tap_count_q;
    assign smp_valid    = smp_valid_q;
    assign smp_data     = smp_data_q;

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        k_d          = k_q;
        rem_d        = rem_q;
        cfg_err_d    = cfg_err_q;
        cont_valid_d = 1'b0;
        cont_num_d   = cont_num_q;
        cont_mode_d  = cont_mode_q;
        tap_valid_d  = 1'b0;
        tap_data_d   = tap_data_q;
        tap_count_d  = tap_count_q;
        smp_valid_d  = 1'b0;
        smp_data_d   = smp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_num != '0) begin
                        cont_valid_d = 1'b1;
                        cont_num_d   = cfg_num;
                        cont_mode_d  = cfg_mode;
                        k_d          = cfg_num - CNT_W'(1);
                        rem_d        = cfg_len;
                        cfg_err_d    = 1'b0;
                        state_d      = ST_CFG;
                    end else begin
                        cfg_err_d    = 1'b1;
                    end
                end
            end
            ST_CFG: begin
                gap_d   = GAP_W'(CFG_GAP);
                state_d = (CFG_GAP == 0) ? ST_TAP : ST_GAP;
            end
            ST_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = ST_TAP;
                end else begin
                    gap_d   = gap_q - GAP_W'(1);
                end
            end
            ST_TAP: begin
                if (tap_in_valid) begin
                    tap_valid_d = 1'b1;
                    tap_data_d  = cpx_t'(tap_in_data);
                    tap_count_d = k_q;
                    k_d         = k_q - CNT_W'(1);
                    // Zero-length frames skip the sample phase entirely.
                    if (k_q == '0) begin
                        state_d = (rem_q == '0) ? ST_IDLE : ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (smp_in_valid && smp_rdy) begin
                    smp_valid_d = 1'b1;
                    smp_data_d  = cpx_t'(smp_in_data);
                    rem_d       = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gap_q        <= '0;
            k_q          <= '0;
            rem_q        <= '0;
            cfg_err_q    <= 1'b0;
            cont_valid_q <= 1'b0;
            cont_num_q   <= '0;
            cont_mode_q  <= '0;
            tap_valid_q  <= 1'b0;
            tap_data_q   <= '0;
            tap_count_q  <= '0;
            smp_valid_q  <= 1'b0;
            smp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            k_q          <= k_d;
            rem_q        <= rem_d;
            cfg_err_q    <= cfg_err_d;
            cont_valid_q <= cont_valid_d;
            cont_num_q   <= cont_num_d;
            cont_mode_q  <= cont_mode_d;
            tap_valid_q  <= tap_valid_d;
            tap_data_q   <= tap_data_d;
            tap_count_q  <= tap_count_d;
            smp_valid_q  <= smp_valid_d;
            smp_data_q   <= smp_data_d;
        end
    end

endmodule

// File: tb/tb_fir_tile_feeder.sv
// Directed bench for fir_tile_feeder: reset, job sequencing, tap indexing, sample gating under tile_ready.
module tb_fir_tile_feeder;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_num;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_len;
    logic        tap_in_valid;
    logic        tap_in_ready;
    logic [31:0] tap_in_data;
    logic        smp_in_valid;
    logic        smp_in_ready;
    logic [31:0] smp_in_data;
    logic        tile_ready;
    logic        cont_valid;
    logic [7:0]  cont_num;
    logic [1:0]  cont_mode;
    logic        tap_valid;
    logic [31:0] tap_data;
    logic [7:0]  tap_count;
    logic        smp_valid;
    logic [31:0] smp_data;
    logic        busy;
    logic        cfg_err;

    int nvec;
    int nerr;

    fir_tile_feeder #(
        .DW(16), .CNT_W(8), .LEN_W(16), .CFG_GAP(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_num(cfg_num), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .tap_in_valid(tap_in_valid), .tap_in_ready(tap_in_ready), .tap_in_data(tap_in_data),
        .smp_in_valid(smp_in_valid), .smp_in_ready(smp_in_ready), .smp_in_data(smp_in_data),
        .tile_ready(tile_ready),
        .cont_valid(cont_valid), .cont_num(cont_num), .cont_mode(cont_mode),
        .tap_valid(tap_valid), .tap_data(tap_data), .tap_count(tap_count),
        .smp_valid(smp_valid), .smp_data(smp_data),
        .busy(busy), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst cont_valid", 32'(cont_valid), 0);
        chk("rst cont_num",   32'(cont_num), 0);
        chk("rst cont_mode",  32'(cont_mode), 0);
        chk("rst tap_valid",  32'(tap_valid), 0);
        chk("rst tap_data",   tap_data, 0);
        chk("rst tap_count",  32'(tap_count), 0);
        chk("rst smp_valid",  32'(smp_valid), 0);
        chk("rst smp_data",   smp_data, 0);
        chk("rst busy",       32'(busy), 0);
        chk("rst cfg_err",    32'(cfg_err), 0);
        chk("rst cfg_ready",  32'(cfg_ready), 1);
        chk("rst tap_in_rdy", 32'(tap_in_ready), 0);
        chk("rst smp_in_rdy", 32'(smp_in_ready), 0);
    endtask

    // Accept a job from IDLE, check the config pulse, the 4-cycle gap, and arrival in TAP.
    task automatic start_job(input logic [7:0] num, input logic [1:0] mode, input logic [15:0] len);
        cfg_valid = 1'b1;
        cfg_num   = num;
        cfg_mode  = mode;
        cfg_len   = len;
        #1;
        chk("cfg_ready idle", 32'(cfg_ready), 1);
        tick();
        cfg_valid = 1'b0;
        chk("cont_valid", 32'(cont_valid), 1);
        chk("cont_num",   32'(cont_num), 32'(num));
        chk("cont_mode",  32'(cont_mode), 32'(mode));
        chk("busy cfg",   32'(busy), 1);
        chk("cfg_ready busy", 32'(cfg_ready), 0);
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("gap cont_valid", 32'(cont_valid), 0);
            chk("gap tap_in_rdy", 32'(tap_in_ready), 0);
            chk("gap smp_in_rdy", 32'(smp_in_ready), 0);
            chk("gap tap_valid",  32'(tap_valid), 0);
        end
        tick();
        chk("tap_in_ready", 32'(tap_in_ready), 1);
    endtask

    task automatic send_tap(input logic [31:0] data, input logic [7:0] cnt);
        tap_in_valid = 1'b1;
        tap_in_data  = data;
        tick();
        tap_in_valid = 1'b0;
        chk("tap_valid", 32'(tap_valid), 1);
        chk("tap_data",  tap_data, data);
        chk("tap_count", 32'(tap_count), 32'(cnt));
        chk("tap smp_valid", 32'(smp_valid), 0);
    endtask

    initial begin
        logic [31:0] exp_smp;
        int          n;
        logic        tr;

        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_num = '0; cfg_mode = '0; cfg_len = '0;
        tap_in_valid = 1'b0; tap_in_data = '0;
        smp_in_valid = 1'b0; smp_in_data = '0;
        tile_ready = 1'b0;
        tick();
        tick();
        chk_reset();
        rst_n = 1'b1;

        // Reset in the middle of the tap phase drops the job.
        start_job(8'd4, 2'd1, 16'd5);
        send_tap(32'h1111_2222, 8'd3);
        send_tap(32'h3333_4444, 8'd2);
        rst_n = 1'b0;
        tap_in_valid = 1'b1;
        tap_in_data = 32'h5555_6666;
        tick();
        chk_reset();
        rst_n = 1'b1;
        tap_in_valid = 1'b0;
        tick();
        chk_reset();

        // num=2, 64-sample frame at full rate, with one host gap in the taps.
        start_job(8'd2, 2'd0, 16'd64);
        send_tap(32'h0002_0000, 8'd1);
        tick();
        chk("host gap tap_valid", 32'(tap_valid), 0);
        chk("host gap tap_in_rdy", 32'(tap_in_ready), 1);
        send_tap(32'h0003_0000, 8'd0);
        chk("stream tap_in_rdy", 32'(tap_in_ready), 0);
        tile_ready = 1'b1;
        smp_in_valid = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            smp_in_data = {16'(i), 16'h0000};
            #1;
            chk("smp_in_ready full", 32'(smp_in_ready), 1);
            tick();
            chk("smp_valid full", 32'(smp_valid), 1);
            chk("smp_data full",  smp_data, {16'(i), 16'h0000});
            chk("busy full",      32'(busy), (i == 64) ? 0 : 1);
        end
        smp_in_valid = 1'b0;

        // Back-to-back job in the first IDLE cycle; tile_ready alternates during an 8-sample frame.
        start_job(8'd1, 2'd3, 16'd8);
        send_tap(32'h1234_5678, 8'd0);
        smp_in_valid = 1'b1;
        n = 0;
        exp_smp = 32'h0000_0000;
        for (int c = 0; c < 16; c++) begin
            tr = (c % 2 == 0);
            tile_ready = tr;
            smp_in_data = {16'(100 + n), 16'(n)};
            #1;
            chk("smp_in_ready gated", 32'(smp_in_ready), 32'(tr));
            tick();
            if (tr) begin
                exp_smp = {16'(100 + n), 16'(n)};
                n++;
            end
            chk("smp_valid gated", 32'(smp_valid), 32'(tr));
            chk("smp_data gated",  smp_data, exp_smp);
        end
        chk("gated sample total", 32'(n), 8);
        chk("gated busy end", 32'(busy), 0);
        tile_ready = 1'b1;
        #1;
        chk("idle smp_in_ready", 32'(smp_in_ready), 0);
        smp_in_valid = 1'b0;

        // num=0 is rejected and flagged; the next good job clears the flag.
        cfg_valid = 1'b1;
        cfg_num = 8'd0;
        cfg_mode = 2'd1;
        cfg_len = 16'd5;
        tick();
        cfg_valid = 1'b0;
        chk("err cfg_err",    32'(cfg_err), 1);
        chk("err cont_valid", 32'(cont_valid), 0);
        chk("err busy",       32'(busy), 0);
        chk("err cfg_ready",  32'(cfg_ready), 1);
        tick();
        chk("err sticky", 32'(cfg_err), 1);
        start_job(8'd1, 2'd2, 16'd0);
        chk("err cleared", 32'(cfg_err), 0);
        send_tap(32'hCAFE_0001, 8'd0);
        chk("num1 len0 busy", 32'(busy), 0);

        // len=0 with three taps: sample path never opens.
        tile_ready = 1'b1;
        smp_in_valid = 1'b1;
        smp_in_data = 32'hDEAD_BEEF;
        start_job(8'd3, 2'd1, 16'd0);
        send_tap(32'hA000_0002, 8'd2);
        chk("len0 smp_in_rdy a", 32'(smp_in_ready), 0);
        send_tap(32'hA000_0001, 8'd1);
        chk("len0 smp_in_rdy b", 32'(smp_in_ready), 0);
        send_tap(32'hA000_0000, 8'd0);
        chk("len0 busy",       32'(busy), 0);
        chk("len0 cfg_ready",  32'(cfg_ready), 1);
        chk("len0 smp_in_rdy", 32'(smp_in_ready), 0);
        tick();
        chk("len0 smp_valid",  32'(smp_valid), 0);
        chk("len0 tap_valid",  32'(tap_valid), 0);
        smp_in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
